// File: rtl/mmio_bridge_intc_if.sv
// CPU MEM-stage data port as seen by the MMIO bridge.
// The CPU drives the master side; the bridge drives the slave side.
interface mmio_bridge_intc_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_load;
    logic        cpu_load_word;
    logic [31:0] cpu_rdata;
    logic        cpu_adel;
    logic        cpu_ades;

    modport master (
        output cpu_addr, cpu_wdata, cpu_byteen, cpu_load, cpu_load_word,
        input  cpu_rdata, cpu_adel, cpu_ades
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_byteen, cpu_load, cpu_load_word,
        output cpu_rdata, cpu_adel, cpu_ades
    );
endinterface

// File: rtl/mmio_bridge_intc.sv
// Address decode, write steering and read mux between the CPU data port, DM and two timers,
// plus a small interrupt controller producing the registered HWInt vector for CP0.
module mmio_bridge_intc #(
    parameter logic [31:0] DM_LIMIT    = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE    = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE    = 32'h0000_7F10,
    parameter logic [31:0] INTC_BASE   = 32'h0000_7F20,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_bridge_intc_if.slave    cpu,
    output logic [31:0]          o_dm_addr,
    output logic [3:0]           o_dm_byteen,
    output logic [31:0]          o_dm_wdata,
    input  logic [31:0]          i_dm_rdata,
    output logic [29:0]          o_tc0_addr,
    output logic [29:0]          o_tc1_addr,
    output logic                 o_tc0_we,
    output logic                 o_tc1_we,
    output logic [31:0]          o_tc_din,
    input  logic [31:0]          i_tc0_dout,
    input  logic [31:0]          i_tc1_dout,
    input  logic                 i_tc0_irq,
    input  logic                 i_tc1_irq,
    input  logic                 i_ext_int_in,
    output logic [5:0]           o_hw_int
);

    // A three-word window: word-aligned offsets 0, 4 and 8 from its base.
    function automatic logic win_hit(input logic [31:0] off);
        return (off < 32'd12) && (off[1:0] == 2'b00);
    endfunction

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_ext_prev;
    logic                   r_ext_pend;
    logic [5:0]             r_mask;
    logic [5:0]             r_hw_int;

    logic [31:0] w_tc0_off, w_tc1_off, w_intc_off;
    logic        w_dm_hit, w_tc0_hit, w_tc1_hit, w_intc_hit;
    logic        w_store, w_full, w_st_ok, w_ld_ok;
    logic        w_tc0_st_ok, w_tc1_st_ok, w_intc_st_ok;
    logic        w_ades, w_adel, w_mask_we, w_ack, w_ext_rise;
    logic [5:0]  w_pend;
    logic [31:0] w_rdata;

    assign w_tc0_off  = cpu.cpu_addr - TC0_BASE;
    assign w_tc1_off  = cpu.cpu_addr - TC1_BASE;
    assign w_intc_off = cpu.cpu_addr - INTC_BASE;

    assign w_dm_hit   = (cpu.cpu_addr <= DM_LIMIT);
    assign w_tc0_hit  = win_hit(w_tc0_off);
    assign w_tc1_hit  = win_hit(w_tc1_off);
    assign w_intc_hit = win_hit(w_intc_off);

    assign w_store = (cpu.cpu_byteen != 4'b0000);
    assign w_full  = (cpu.cpu_byteen == 4'b1111);

    // Timer COUNT (offset 8) is read-only; INTC offset 8 is the write-only ACK register.
    assign w_tc0_st_ok  = w_tc0_hit && w_full && (w_tc0_off != 32'd8);
    assign w_tc1_st_ok  = w_tc1_hit && w_full && (w_tc1_off != 32'd8);
    assign w_intc_st_ok = w_intc_hit && w_full;
    assign w_st_ok      = w_dm_hit || w_tc0_st_ok || w_tc1_st_ok || w_intc_st_ok;
    assign w_ld_ok      = w_dm_hit || ((w_tc0_hit || w_tc1_hit || w_intc_hit) && cpu.cpu_load_word);

    assign w_ades = w_store && !w_st_ok;
    assign w_adel = cpu.cpu_load && !w_ld_ok;

    assign w_mask_we  = w_store && w_intc_st_ok && (w_intc_off == 32'd4);
    assign w_ack      = w_store && w_intc_st_ok && (w_intc_off == 32'd8) && cpu.cpu_wdata[2];
    assign w_ext_rise = r_sync[SYNC_STAGES-1] && !r_ext_prev;
    assign w_pend     = {3'b000, r_ext_pend, i_tc1_irq, i_tc0_irq};

    // Combinational load-data mux; illegal or unmapped loads return zero.
    always_comb begin
        w_rdata = 32'h0000_0000;
        if (w_adel) begin
            w_rdata = 32'h0000_0000;
        end else if (w_dm_hit) begin
            w_rdata = i_dm_rdata;
        end else if (w_tc0_hit) begin
            w_rdata = i_tc0_dout;
        end else if (w_tc1_hit) begin
            w_rdata = i_tc1_dout;
        end else if (w_intc_hit) begin
            case (w_intc_off[3:2])
                2'd0:    w_rdata = {26'd0, w_pend};
                2'd1:    w_rdata = {26'd0, r_mask};
                default: w_rdata = 32'h0000_0000;
            endcase
        end else begin
            w_rdata = 32'h0000_0000;
        end
    end

    // Interrupt state: synchroniser, sticky external pending bit, mask and output vector.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync     <= '0;
            r_ext_prev <= 1'b0;
            r_ext_pend <= 1'b0;
            r_mask     <= 6'b000111;
            r_hw_int   <= 6'b000000;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], i_ext_int_in};
            r_ext_prev <= r_sync[SYNC_STAGES-1];
            // A new edge beats a same-cycle ACK so no interrupt is lost.
            if (w_ext_rise) begin
                r_ext_pend <= 1'b1;
            end else if (w_ack) begin
                r_ext_pend <= 1'b0;
            end else begin
                r_ext_pend <= r_ext_pend;
            end
            if (w_mask_we) begin
                r_mask <= cpu.cpu_wdata[5:0];
            end else begin
                r_mask <= r_mask;
            end
            r_hw_int <= w_pend & r_mask;
        end
    end

    assign cpu.cpu_rdata = w_rdata;
    assign cpu.cpu_adel  = w_adel;
    assign cpu.cpu_ades  = w_ades;

    assign o_dm_addr   = cpu.cpu_addr;
    assign o_dm_wdata  = cpu.cpu_wdata;
    assign o_dm_byteen = w_dm_hit ? cpu.cpu_byteen : 4'b0000;
    assign o_tc0_addr  = cpu.cpu_addr[31:2];
    assign o_tc1_addr  = cpu.cpu_addr[31:2];
    assign o_tc0_we    = w_store && w_tc0_st_ok;
    assign o_tc1_we    = w_store && w_tc1_st_ok;
    assign o_tc_din    = cpu.cpu_wdata;
    assign o_hw_int    = r_hw_int;

endmodule

// File: tb/tb_mmio_bridge_intc.sv
// Scoreboard bench for mmio_bridge_intc: expectations are queued when stimulus is driven
// and popped against the observed DUT output away from the active clock edge.
module tb_mmio_bridge_intc;

    logic        clk;
    logic        reset;
    logic [31:0] dm_addr, dm_wdata, dm_rdata, tc_din, tc0_dout, tc1_dout;
    logic [3:0]  dm_byteen;
    logic [29:0] tc0_addr, tc1_addr;
    logic        tc0_we, tc1_we, tc0_irq, tc1_irq, ext_int_in;
    logic [5:0]  hw_int;

    int n_compared;
    int n_mismatched;

    mmio_bridge_intc_if bus ();

    mmio_bridge_intc dut (
        .clk          (clk),
        .reset        (reset),
        .cpu          (bus),
        .o_dm_addr    (dm_addr),
        .o_dm_byteen  (dm_byteen),
        .o_dm_wdata   (dm_wdata),
        .i_dm_rdata   (dm_rdata),
        .o_tc0_addr   (tc0_addr),
        .o_tc1_addr   (tc1_addr),
        .o_tc0_we     (tc0_we),
        .o_tc1_we     (tc1_we),
        .o_tc_din     (tc_din),
        .i_tc0_dout   (tc0_dout),
        .i_tc1_dout   (tc1_dout),
        .i_tc0_irq    (tc0_irq),
        .i_tc1_irq    (tc1_irq),
        .i_ext_int_in (ext_int_in),
        .o_hw_int     (hw_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {S_RDATA, S_ADEL, S_ADES, S_DMBE, S_TC0WE, S_TC1WE, S_TC0ADDR, S_HWINT, S_DMADDR, S_TCDIN} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sel_e sel);
        case (sel)
            S_RDATA:   return bus.cpu_rdata;
            S_ADEL:    return {31'd0, bus.cpu_adel};
            S_ADES:    return {31'd0, bus.cpu_ades};
            S_DMBE:    return {28'd0, dm_byteen};
            S_TC0WE:   return {31'd0, tc0_we};
            S_TC1WE:   return {31'd0, tc1_we};
            S_TC0ADDR: return {2'd0, tc0_addr};
            S_HWINT:   return {26'd0, hw_int};
            S_DMADDR:  return dm_addr;
            S_TCDIN:   return tc_din;
            default:   return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic expect_out(input string tag, input sel_e sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Pops every queued expectation and compares it against the DUT as it stands now.
    task automatic sb_drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                         input logic ld, input logic lw);
        bus.cpu_addr      = a;
        bus.cpu_wdata     = wd;
        bus.cpu_byteen    = be;
        bus.cpu_load      = ld;
        bus.cpu_load_word = lw;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        drive(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset      = 1'b1;
        dm_rdata   = 32'h0;
        tc0_dout   = 32'h0;
        tc1_dout   = 32'h0;
        tc0_irq    = 1'b0;
        tc1_irq    = 1'b0;
        ext_int_in = 1'b0;
        drive(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        drive(32'h0000_7F24, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("rst_hw_int", S_HWINT, 32'h0);
        expect_out("rst_mask", S_RDATA, 32'h7);
        sb_drain();

        // DM store and load routing.
        @(negedge clk);
        drive(32'h0000_0010, 32'h1234_5678, 4'b1111, 1'b0, 1'b0);
        expect_out("dm_sw_be", S_DMBE, 32'hF);
        expect_out("dm_sw_tc0we", S_TC0WE, 32'h0);
        expect_out("dm_sw_tc1we", S_TC1WE, 32'h0);
        expect_out("dm_sw_ades", S_ADES, 32'h0);
        expect_out("dm_sw_addr", S_DMADDR, 32'h0000_0010);
        sb_drain();
        @(negedge clk);
        dm_rdata = 32'h0000_00A5;
        drive(32'h0000_0010, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("dm_lw_rdata", S_RDATA, 32'hA5);
        expect_out("dm_lw_adel", S_ADEL, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_2FFC, 32'h0, 4'b0000, 1'b1, 1'b0);
        expect_out("dm_top_adel", S_ADEL, 32'h0);
        expect_out("dm_top_rdata", S_RDATA, 32'hA5);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_3000, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("dm_past_adel", S_ADEL, 32'h1);
        expect_out("dm_past_rdata", S_RDATA, 32'h0);
        sb_drain();

        // Timer routing and illegal timer accesses.
        @(negedge clk);
        drive(32'h0000_7F00, 32'h0000_0009, 4'b1111, 1'b0, 1'b0);
        expect_out("tc0_sw_we", S_TC0WE, 32'h1);
        expect_out("tc0_sw_addr", S_TC0ADDR, 32'h1FC0);
        expect_out("tc0_sw_din", S_TCDIN, 32'h9);
        expect_out("tc0_sw_ades", S_ADES, 32'h0);
        expect_out("tc0_sw_dmbe", S_DMBE, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F18, 32'h0000_0001, 4'b1111, 1'b0, 1'b0);
        expect_out("tc1_cnt_ades", S_ADES, 32'h1);
        expect_out("tc1_cnt_we", S_TC1WE, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F04, 32'h0000_0001, 4'b0001, 1'b0, 1'b0);
        expect_out("tc0_sb_ades", S_ADES, 32'h1);
        expect_out("tc0_sb_we", S_TC0WE, 32'h0);
        sb_drain();
        @(negedge clk);
        tc1_dout = 32'hDEAD_BEEF;
        drive(32'h0000_7F14, 32'h0, 4'b0000, 1'b1, 1'b0);
        expect_out("tc1_lh_adel", S_ADEL, 32'h1);
        expect_out("tc1_lh_rdata", S_RDATA, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F14, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("tc1_lw_rdata", S_RDATA, 32'hDEAD_BEEF);
        sb_drain();

        // Unmapped accesses and the no-access case.
        @(negedge clk);
        drive(32'h0000_4000, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("unmap_lw_adel", S_ADEL, 32'h1);
        expect_out("unmap_lw_rdata", S_RDATA, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F30, 32'h0000_0001, 4'b1111, 1'b0, 1'b0);
        expect_out("unmap_sw_ades", S_ADES, 32'h1);
        expect_out("unmap_sw_dmbe", S_DMBE, 32'h0);
        expect_out("unmap_sw_tc0we", S_TC0WE, 32'h0);
        expect_out("unmap_sw_tc1we", S_TC1WE, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_4000, 32'h0, 4'b0000, 1'b0, 1'b0);
        expect_out("noacc_ades", S_ADES, 32'h0);
        expect_out("noacc_adel", S_ADEL, 32'h0);
        sb_drain();

        // Masking: timer 1 irq, then mask it off with a MASK write.
        @(negedge clk);
        drive(32'h0, 32'h0, 4'b0000, 1'b0, 1'b0);
        tc1_irq = 1'b1;
        @(negedge clk);
        expect_out("tc1_irq_hw", S_HWINT, 32'h02);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F24, 32'h0000_0005, 4'b1111, 1'b0, 1'b0);
        idle_cycle();
        expect_out("mask_wr_plus1", S_HWINT, 32'h02);
        sb_drain();
        idle_cycle();
        expect_out("mask_wr_plus2", S_HWINT, 32'h00);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F24, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("mask_rd", S_RDATA, 32'h5);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F20, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("status_tc1", S_RDATA, 32'h2);
        sb_drain();

        // External interrupt: SYNC_STAGES+2 cycles to hw_int, sticky after the input drops.
        idle_cycle();
        tc1_irq    = 1'b0;
        ext_int_in = 1'b1;
        repeat (3) idle_cycle();
        expect_out("ext_plus3", S_HWINT, 32'h00);
        sb_drain();
        idle_cycle();
        expect_out("ext_plus4", S_HWINT, 32'h04);
        sb_drain();
        ext_int_in = 1'b0;
        repeat (4) idle_cycle();
        expect_out("ext_sticky", S_HWINT, 32'h04);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F20, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("status_ext", S_RDATA, 32'h4);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F28, 32'h0000_0004, 4'b1111, 1'b0, 1'b0);
        expect_out("ack_ades", S_ADES, 32'h0);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F20, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("status_acked", S_RDATA, 32'h0);
        sb_drain();

        // New edge coincident with ACK: the set wins.
        idle_cycle();
        ext_int_in = 1'b1;
        idle_cycle();
        @(negedge clk);
        drive(32'h0000_7F28, 32'h0000_0004, 4'b1111, 1'b0, 1'b0);
        @(negedge clk);
        drive(32'h0000_7F20, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("status_set_wins", S_RDATA, 32'h4);
        sb_drain();

        // Reset with ext_pend set and MASK cleared; a same-cycle MASK write is discarded.
        ext_int_in = 1'b0;
        @(negedge clk);
        drive(32'h0000_7F24, 32'h0000_0000, 4'b1111, 1'b0, 1'b0);
        repeat (2) idle_cycle();
        expect_out("mask0_hw", S_HWINT, 32'h00);
        sb_drain();
        repeat (3) idle_cycle();
        @(negedge clk);
        drive(32'h0000_7F24, 32'h0000_003F, 4'b1111, 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0000_7F24, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("rst2_hw_int", S_HWINT, 32'h00);
        expect_out("rst2_mask", S_RDATA, 32'h7);
        sb_drain();
        @(negedge clk);
        drive(32'h0000_7F20, 32'h0, 4'b0000, 1'b1, 1'b1);
        expect_out("rst2_status", S_RDATA, 32'h0);
        expect_out("rst2_hw_after", S_HWINT, 32'h00);
        sb_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
